// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch, decode and execute stages:
// opcode encodings, instruction field positions, the halt word and the
// fetch state enumeration.
package isa_pkg;

  localparam logic [2:0] OP_J      = 3'b000;
  localparam logic [2:0] OP_BEQ    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SHIFTL = 3'b100;
  localparam logic [2:0] OP_ADDI   = 3'b110;
  localparam logic [2:0] OP_SUBI   = 3'b111;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 29;
  localparam int RS_HI  = 28;
  localparam int RS_LO  = 24;
  localparam int RT_HI  = 23;
  localparam int RT_LO  = 19;
  localparam int RD_HI  = 18;
  localparam int RD_LO  = 14;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 4;
  localparam int TGT_LO = 0;

  localparam logic [31:0] HALT_WORD = 32'h0;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational instruction
// memory, resolves unconditional jumps locally, takes branch redirects
// from execute and hands fetched words to decode over valid/ready.
module instr_fetch_unit
  import isa_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 5,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_out_valid;
  logic              w_out_valid_nxt;
  logic [DATA_W-1:0] r_out_instr;
  logic [DATA_W-1:0] w_out_instr_nxt;
  logic [ADDR_W-1:0] r_out_pc;
  logic [ADDR_W-1:0] w_out_pc_nxt;

  logic [2:0]        w_opcode;
  logic [ADDR_W-1:0] w_target;
  logic              w_accept;

  assign w_opcode = imem_instr[OPC_HI:OPC_LO];
  assign w_target = imem_instr[ADDR_W-1:0];
  assign w_accept = (r_state == FETCH_RUN) && (!r_out_valid || out_ready);

  // State, PC and output register update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= FETCH_RUN;
      r_pc        <= RESET_PC;
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_pc    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_instr <= w_out_instr_nxt;
      r_out_pc    <= w_out_pc_nxt;
    end
  end

  // Next-state selection: redirect wins, then halt word, jump, normal fetch
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_out_valid_nxt = r_out_valid;
    w_out_instr_nxt = r_out_instr;
    w_out_pc_nxt    = r_out_pc;

    if (redirect_valid) begin
      w_pc_nxt        = redirect_pc;
      w_out_valid_nxt = 1'b0;
      w_state_nxt     = FETCH_RUN;
    end else if (r_state == FETCH_HALT) begin
      if (out_ready) begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (w_accept) begin
      if (imem_instr == HALT_WORD) begin
        w_state_nxt = FETCH_HALT;
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
        end
      end else if (w_opcode == OP_J) begin
        w_pc_nxt = w_target;
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
        end
      end else begin
        w_out_instr_nxt = imem_instr;
        w_out_pc_nxt    = r_pc;
        w_out_valid_nxt = 1'b1;
        w_pc_nxt        = r_pc + ADDR_W'(1);
      end
    end
  end

  assign imem_addr = r_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign halted    = (r_state == FETCH_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed program walk-through followed
// by randomized memory contents and handshake/redirect/reset traffic
// compared against an architectural model of fetch.
module tb_instr_fetch_unit;
  import isa_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [4:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [4:0]  out_pc;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        halted;

  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  // Architectural model: PC, halt flag and the one-entry output slot
  logic [4:0]  m_pc;
  logic        m_halt;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [4:0]  m_opc;

  logic [31:0] addWord;

  instr_fetch_unit #(
    .ADDR_W  (5),
    .DATA_W  (32),
    .RESET_PC(5'd0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted)
  );

  assign imem_instr = mem[imem_addr];

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One edge of the architectural model, using the inputs about to be sampled
  task automatic model_step();
    logic [31:0] w;
    w = mem[m_pc];
    if (!rst_n) begin
      m_pc = 5'd0; m_halt = 1'b0; m_valid = 1'b0; m_instr = '0; m_opc = '0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 1'b0; m_halt = 1'b0;
    end else if (m_halt) begin
      if (out_ready) m_valid = 1'b0;
    end else if (m_valid && !out_ready) begin
      m_valid = 1'b1;
    end else if (w == 32'h0) begin
      m_halt = 1'b1;
      if (out_ready) m_valid = 1'b0;
    end else if (w[31:29] == 3'b000) begin
      m_pc = w[4:0];
      if (out_ready) m_valid = 1'b0;
    end else begin
      m_valid = 1'b1; m_instr = w; m_opc = m_pc; m_pc = 5'((int'(m_pc) + 1) % 32);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    checks++;
    if ({out_valid, out_instr, out_pc, imem_addr, halted} !== {1'b0, 32'h0, 5'd0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset got v=%b i=%h pc=%0d a=%0d h=%b exp all zero",
               out_valid, out_instr, out_pc, imem_addr, halted);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({out_valid, out_pc} !== {1'b1, 5'(i)}) begin
        errors++;
        $display("FAIL seq_pc got v=%b pc=%0d exp v=1 pc=%0d", out_valid, out_pc, i);
      end
      if (i == 2) begin
        checks++;
        if (out_instr !== addWord) begin
          errors++;
          $display("FAIL seq_add_word got %h exp %h", out_instr, addWord);
        end
      end
    end
  endtask

  task automatic test_jump();
    tick();
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 5'd12}) begin
      errors++;
      $display("FAIL jump_bubble got v=%b a=%0d exp v=0 a=12", out_valid, imem_addr);
    end
    for (int i = 12; i < 14; i++) begin
      tick();
      checks++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 5'(i), mem[i]}) begin
        errors++;
        $display("FAIL jump_target got v=%b pc=%0d i=%h exp pc=%0d i=%h",
                 out_valid, out_pc, out_instr, i, mem[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 5'd13, mem[13], 5'd14}) begin
        errors++;
        $display("FAIL stall_hold got v=%b pc=%0d i=%h a=%0d exp v=1 pc=13 a=14",
                 out_valid, out_pc, out_instr, imem_addr);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 5'd14}) begin
      errors++;
      $display("FAIL stall_release got v=%b pc=%0d exp v=1 pc=14", out_valid, out_pc);
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 5'd21;
    tick();
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 5'd21}) begin
      errors++;
      $display("FAIL redirect_flush got v=%b a=%0d exp v=0 a=21", out_valid, imem_addr);
    end
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 5'd14}) begin
      errors++;
      $display("FAIL redirect_jump got v=%b a=%0d exp v=0 a=14", out_valid, imem_addr);
    end
    tick();
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 5'd14}) begin
      errors++;
      $display("FAIL redirect_emit got v=%b pc=%0d exp v=1 pc=14", out_valid, out_pc);
    end
  endtask

  task automatic test_halt();
    redirect_valid = 1'b1; redirect_pc = 5'd22;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({halted, out_valid, imem_addr} !== {1'b1, 1'b0, 5'd22}) begin
        errors++;
        $display("FAIL halt_state got h=%b v=%b a=%0d exp h=1 v=0 a=22",
                 halted, out_valid, imem_addr);
      end
    end
    redirect_valid = 1'b1; redirect_pc = 5'd0;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({halted, out_valid, imem_addr} !== {1'b0, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL halt_exit got h=%b v=%b a=%0d exp h=0 v=0 a=0", halted, out_valid, imem_addr);
    end
    tick();
    checks++;
    if ({out_valid, out_pc} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL halt_resume got v=%b pc=%0d exp v=1 pc=0", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap_reset();
    redirect_valid = 1'b1; redirect_pc = 5'd31;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_pc, imem_addr} !== {1'b1, 5'd31, 5'd0}) begin
      errors++;
      $display("FAIL wrap got v=%b pc=%0d a=%0d exp v=1 pc=31 a=0", out_valid, out_pc, imem_addr);
    end
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_pc, out_instr, imem_addr, halted} !== {1'b0, 5'd0, 32'h0, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_stall got v=%b pc=%0d i=%h a=%0d h=%b exp all zero",
               out_valid, out_pc, out_instr, imem_addr, halted);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int r;
    for (int a = 0; a < 32; a++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      mem[a] = 32'h0;
      else if (r <= 2) mem[a] = {OP_J, 24'($urandom), 5'($urandom)};
      else if (r <= 4) mem[a] = {OP_ADD, 29'($urandom)};
      else if (r == 5) mem[a] = {OP_BEQ, 29'($urandom)};
      else if (r == 6) mem[a] = {OP_SHIFTL, 29'($urandom)};
      else if (r == 7) mem[a] = {OP_SUBI, 29'($urandom)};
      else             mem[a] = {OP_ADDI, 29'($urandom) | 29'd1};
    end
    rst_n = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 800; c++) begin
      rst_n          = ($urandom_range(0, 99) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = 5'($urandom);
      tick();
      checks++;
      if ({out_valid, halted, imem_addr} !== {m_valid, m_halt, m_pc} ||
          (m_valid && {out_pc, out_instr} !== {m_opc, m_instr})) begin
        errors++;
        $display("FAIL random_c%0d got v=%b h=%b a=%0d pc=%0d i=%h exp v=%b h=%b a=%0d pc=%0d i=%h",
                 c, out_valid, halted, imem_addr, out_pc, out_instr,
                 m_valid, m_halt, m_pc, m_opc, m_instr);
      end
    end
  endtask

  // Test sequence
  initial begin
    addWord = {OP_ADD, 5'd10, 5'd15, 5'd25, 14'd0};
    for (int a = 0; a < 32; a++) mem[a] = {OP_ADDI, 24'h0, 5'(a)};
    mem[2]  = addWord;
    mem[5]  = {OP_J, 24'h0, 5'd12};
    mem[21] = {OP_J, 24'h0, 5'd14};
    mem[22] = HALT_WORD;
    m_pc = '0; m_halt = 1'b0; m_valid = 1'b0; m_instr = '0; m_opc = '0;

    test_reset();
    test_sequential();
    test_jump();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap_reset();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
